led_status_driver: RTL and testbench
====================================

Name: led_status_driver

Overview:
- Output-side counterpart to the switch debounce/conditioning chain: takes the 4-bit self-destruct count and the armed flag, and drives the four physical LEDs.
- Shows the count in binary with PWM brightness while counting.
- Switches to a sticky all-LED blink alarm when the terminal count is reached.
- Sits between the count logic and the LED pins; replaces direct count-to-LED wiring.

Parameters:
TICK_DIV, 120000, clk cycles per blink tick (10 ms at 12 MHz); range 2..2^17-1
BLINK_TICKS, 25, ticks per blink half-period (250 ms); range 1..255
TERMINAL, 11, cnt_in value that triggers ALARM; 4-bit

Ports:
clk  in  1  system clock, 12 MHz
reset  in  1  synchronous, active-low reset
cnt_in  in  4  count from the self-destruct counter, sampled every clk
armed  in  1  debounced arm/in-combat flag; low forces IDLE
brightness  in  4  PWM duty, 0 = off, 15 = full on, otherwise duty = brightness/15
leds  out  4  registered LED drive, 1 = lit
state_out  out  2  current state: 0 IDLE, 1 COUNT, 2 ALARM

Behaviour:
- All state is updated on posedge clk. reset==0 on an edge forces the following, taking priority over everything else and applicable mid-blink or mid-PWM:
  - leds=0, state IDLE
  - tick counter=0, blink counter=0, blink phase=0 (off)
  - pwm counter=0
- PWM counter:
  - free-running 0..14, wraps 14 to 0 (15-step period)
  - pwm_on = (pwm_cnt < brightness); brightness=15 is always on, brightness=0 is always off.
- Tick prescaler:
  - counts 0..TICK_DIV-1; tick asserts for one clk when the count wraps.
  - Runs only in ALARM; cleared on entry to ALARM.
- State machine:
  - IDLE: armed==1 goes to COUNT, or to ALARM if cnt_in==TERMINAL in the same cycle.
  - COUNT: armed==0 goes to IDLE; otherwise cnt_in==TERMINAL goes to ALARM.
  - ALARM: sticky. Exits only on armed==0 (to IDLE) or reset; cnt_in changes are ignored.
  - armed==0 wins over TERMINAL when both occur in the same cycle.
- LED output (registered, one clk latency from the state/inputs of the previous edge):
  - IDLE: leds=0000.
  - COUNT: leds = pwm_on ? cnt_in : 0000.
  - ALARM: leds = blink_phase ? 1111 : 0000. Not PWM-gated; the alarm is always full brightness.
- Blink:
  - On ALARM entry: blink_phase=1, blink_cnt=0.
  - Each tick increments blink_cnt; when blink_cnt reaches BLINK_TICKS-1 on a tick, it clears and blink_phase toggles.
  - Therefore the first lit interval = BLINK_TICKS*TICK_DIV clk (±1 on entry).
- cnt_in values above TERMINAL (12..15) in COUNT: displayed as-is; no alarm.
- state_out is a registered mirror of the state register.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=0, ST_COUNT=1, ST_ALARM=2
  - default TERMINAL=11
  - CLK_HZ=12000000
- One natural sub-module: tick_prescaler (enable, clear, tick output, TICK_DIV parameter), reusable by the 10 ms divider users.
- PWM and FSM stay in the top block.

Test Plan:
All scenarios use TICK_DIV=4, BLINK_TICKS=2 for simulation.
1. Reset: hold reset=0 for 3 clk with armed=1, cnt_in=5, brightness=15 -> leds=0000 and state_out=0 throughout; first edge after release gives state_out=1, and leds=0101 on the next clk.
2. PWM: armed=1, cnt_in=0011, brightness=5 over 30 clk -> leds=0011 on exactly 10 clk, 0000 on 20 clk, period 15; brightness=0 gives leds always 0000; brightness=15 gives always 0011.
3. Alarm entry and blink: cnt_in goes 10 -> 11 while armed -> state_out=2 on the next clk; leds=1111 for 8 clk, 0000 for 8 clk, repeating. Changing cnt_in back to 3 keeps state_out=2.
4. Disarm mid-alarm: armed 1 -> 0 during a lit phase -> state_out=0 and leds=0000 one clk later. Re-arm with cnt_in=2 -> COUNT, and the blink counters restart on the next alarm entry.
5. Simultaneous events: in COUNT, the same cycle has armed=0 and cnt_in=11 -> IDLE, never ALARM. In IDLE, armed=1 with cnt_in=11 -> direct to ALARM.
6. Reset mid-blink: reset=0 for 1 clk during the dark phase of ALARM -> all outputs 0, state IDLE. After release, with armed=1 and cnt_in=11 -> ALARM again, and the first phase is lit for a full 8 clk.

Source files
------------

// File: rtl/led_status_driver_pkg.sv
// Shared definitions for the LED status driver: state encoding and design defaults.
package led_status_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  localparam logic [3:0] TERMINAL_DEFAULT = 4'd11;
  localparam int unsigned CLK_HZ          = 12_000_000;
  localparam logic [3:0] PWM_LAST         = 4'd14;  // 15-step PWM period, counts 0..14

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a one-clk tick every TICK_DIV enabled cycles; clear restarts the count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_status_driver.sv
// Drives four LEDs from the self-destruct count: PWM-dimmed binary while counting,
// sticky full-brightness blink once the terminal count is reached.
module led_status_driver
  import led_status_driver_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 120000,
  parameter int unsigned BLINK_TICKS = 25,
  parameter logic [3:0]  TERMINAL    = TERMINAL_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_in,
  input  logic       armed,
  input  logic [3:0] brightness,
  output logic [3:0] leds,
  output logic [1:0] state_out
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] pwm_cnt;
  logic       pwm_on;
  logic [7:0] blink_cnt;
  logic       blink_phase;
  logic       tick;
  logic       entering_alarm;

  assign state_out = state_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (armed) state_d = (cnt_in == TERMINAL) ? ST_ALARM : ST_COUNT;
      ST_COUNT: if (!armed) state_d = ST_IDLE;
                else if (cnt_in == TERMINAL) state_d = ST_ALARM;
      ST_ALARM: if (!armed) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign entering_alarm = (state_q != ST_ALARM) && (state_d == ST_ALARM);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Free-running PWM; brightness 15 exceeds every count value so it is always on.
  always_ff @(posedge clk) begin
    if (!reset)                pwm_cnt <= '0;
    else if (pwm_cnt == PWM_LAST) pwm_cnt <= '0;
    else                       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign pwm_on = (pwm_cnt < brightness);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_ALARM),
    .clear  (state_q != ST_ALARM),
    .tick   (tick)
  );

  // Blink starts lit with a fresh half-period on every alarm entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (entering_alarm) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (state_q != ST_ALARM) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      leds <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE:  leds <= 4'b0000;
        ST_COUNT: leds <= pwm_on ? cnt_in : 4'b0000;
        ST_ALARM: leds <= {4{blink_phase}};
        default:  leds <= 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Self-checking bench for led_status_driver: vector table, directed corner sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_led_status_driver;

  localparam int TD = 4;
  localparam int BT = 2;
  localparam int HALF = TD * BT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cnt_in = '0;
  logic       armed = 1'b0;
  logic [3:0] brightness = '0;
  logic [3:0] leds;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;

  // Reference model: state as 0/1/2, pwm step count since reset, edges since alarm entry.
  int m_state = 0;
  int m_n = 0;
  int m_age = 0;
  int m_leds = 0;

  always #5 clk = ~clk;

  led_status_driver #(
    .TICK_DIV    (TD),
    .BLINK_TICKS (BT),
    .TERMINAL    (4'd11)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .armed      (armed),
    .brightness (brightness),
    .leds       (leds),
    .state_out  (state_out)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic a, input int c, input int b);
    int nxt;
    bit lit;
    if (!r) begin
      m_leds = 0; m_state = 0; m_n = 0; m_age = 0;
    end else begin
      lit = ((m_age / HALF) % 2) == 0;
      case (m_state)
        1:       m_leds = ((m_n % 15) < b) ? c : 0;
        2:       m_leds = lit ? 15 : 0;
        default: m_leds = 0;
      endcase
      if (!a)                nxt = 0;
      else if (m_state == 2) nxt = 2;
      else                   nxt = (c == 11) ? 2 : 1;
      if (nxt == 2 && m_state != 2) m_age = 0;
      else if (nxt == 2)            m_age++;
      m_state = nxt;
      m_n++;
    end
  endtask

  task automatic step(input logic r, input logic a, input logic [3:0] c, input logic [3:0] b);
    reset = r; armed = a; cnt_in = c; brightness = b;
    @(posedge clk);
    model_edge(r, a, int'(c), int'(b));
    #1;
    check("model_leds", 32'(leds), 32'(m_leds));
    check("model_state", 32'(state_out), 32'(m_state));
  endtask

  typedef struct {
    logic       r;
    logic       a;
    logic [3:0] c;
    logic [3:0] b;
    logic [3:0] exp_leds;
    logic [1:0] exp_state;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int lit;
    int bad;
    logic [3:0] exp;

    // Reset hold, release, display, above-terminal value, disarm-vs-terminal, direct alarm.
    tbl[0]  = '{1'b0, 1'b1, 4'd5,  4'd15, 4'h0, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 4'd5,  4'd15, 4'h0, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 4'd5,  4'd15, 4'h0, 2'd0};
    tbl[3]  = '{1'b1, 1'b1, 4'd5,  4'd15, 4'h0, 2'd1};
    tbl[4]  = '{1'b1, 1'b1, 4'd5,  4'd15, 4'h5, 2'd1};
    tbl[5]  = '{1'b1, 1'b1, 4'd12, 4'd15, 4'hC, 2'd1};
    tbl[6]  = '{1'b1, 1'b0, 4'd11, 4'd15, 4'hB, 2'd0};
    tbl[7]  = '{1'b1, 1'b0, 4'd11, 4'd15, 4'h0, 2'd0};
    tbl[8]  = '{1'b1, 1'b1, 4'd11, 4'd15, 4'h0, 2'd2};
    tbl[9]  = '{1'b1, 1'b1, 4'd3,  4'd15, 4'hF, 2'd2};
    tbl[10] = '{1'b1, 1'b0, 4'd3,  4'd15, 4'hF, 2'd0};
    tbl[11] = '{1'b1, 1'b0, 4'd3,  4'd15, 4'h0, 2'd0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].c, tbl[i].b);
      check($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].exp_leds));
      check($sformatf("tbl%0d_state", i), 32'(state_out), 32'(tbl[i].exp_state));
    end

    // PWM duty: brightness 5 lights 10 of every 30 cycles; 0 never; 15 always.
    step(1'b0, 1'b1, 4'd3, 4'd5);
    step(1'b1, 1'b1, 4'd3, 4'd5);
    lit = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 4'd3, 4'd5);
      if (leds == 4'd3) lit++;
    end
    check("pwm_b5_lit", 32'(lit), 32'd10);
    lit = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 4'd3, 4'd0);
      if (leds != 4'd0) lit++;
    end
    check("pwm_b0_lit", 32'(lit), 32'd0);
    lit = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 4'd3, 4'd15);
      if (leds == 4'd3) lit++;
    end
    check("pwm_b15_lit", 32'(lit), 32'd15);

    // Alarm entry, 8-on/8-off blink, cnt_in changes ignored.
    step(1'b1, 1'b1, 4'd10, 4'd15);
    step(1'b1, 1'b1, 4'd11, 4'd15);
    check("alarm_entry_state", 32'(state_out), 32'd2);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      step(1'b1, 1'b1, (k > 16) ? 4'd3 : 4'd11, 4'd7);
      exp = (((k - 1) / HALF) % 2 == 0) ? 4'hF : 4'h0;
      if (leds !== exp || state_out !== 2'd2) bad++;
    end
    check("blink_pattern_bad", 32'(bad), 32'd0);

    // Disarm during a lit phase, then re-arm and re-enter with a fresh blink.
    step(1'b1, 1'b1, 4'd3, 4'd15);
    check("lit_before_disarm", 32'(leds), 32'hF);
    step(1'b1, 1'b0, 4'd3, 4'd15);
    check("disarm_state", 32'(state_out), 32'd0);
    step(1'b1, 1'b0, 4'd3, 4'd15);
    check("disarm_leds", 32'(leds), 32'd0);
    step(1'b1, 1'b1, 4'd2, 4'd15);
    check("rearm_count", 32'(state_out), 32'd1);
    step(1'b1, 1'b1, 4'd11, 4'd15);
    lit = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 4'd11, 4'd15);
      if (leds == 4'hF) lit++;
    end
    check("reentry_lit_len", 32'(lit), 32'd8);
    step(1'b1, 1'b1, 4'd11, 4'd15);
    check("reentry_dark", 32'(leds), 32'd0);

    // Reset during the dark phase, then straight back to ALARM from IDLE.
    step(1'b1, 1'b1, 4'd11, 4'd15);
    step(1'b0, 1'b1, 4'd11, 4'd15);
    check("midblink_rst_leds", 32'(leds), 32'd0);
    check("midblink_rst_state", 32'(state_out), 32'd0);
    step(1'b1, 1'b1, 4'd11, 4'd15);
    check("post_rst_alarm", 32'(state_out), 32'd2);
    lit = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 4'd11, 4'd15);
      if (leds == 4'hF) lit++;
    end
    check("post_rst_lit_len", 32'(lit), 32'd8);
    step(1'b1, 1'b1, 4'd11, 4'd15);
    check("post_rst_dark", 32'(leds), 32'd0);

    // Randomized traffic, every cycle compared against the model inside step().
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 39) != 0,
           ($urandom_range(0, 7) == 0) ? 4'd11 : 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
